// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared binary/Gray conversion helpers and step encoding
//
// Purpose: width-generic Gray-code helpers reused by any block that needs
// one-bit-change-per-step sequences or pointers. Values narrower than
// GRAY_MAXW are passed zero-extended; the zero upper bits make both
// conversions exact for the live low bits, so callers just truncate the
// result back to their own width.
//
// Contents:
//   GRAY_MAXW   widest supported counter
//   gray_word_t container type for all helper arguments and results
//   step_e      kind of update a counter performs on a clock edge
//   bin2gray    binary -> Gray
//   gray2bin    Gray -> binary (XOR prefix from the MSB down)
//   gray_max    all-ones value of a given width
package gray_pkg;

   localparam int GRAY_MAXW = 32;

   typedef logic [GRAY_MAXW-1:0] gray_word_t;

   typedef enum logic [1:0] {
      STEP_HOLD = 2'd0,
      STEP_LOAD = 2'd1,
      STEP_INC  = 2'd2,
      STEP_DEC  = 2'd3
   } step_e;

   function automatic gray_word_t bin2gray(input gray_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Bit i of the binary value is the XOR of all Gray bits from the MSB down to i.
   function automatic gray_word_t gray2bin(input gray_word_t g);
      gray_word_t b;
      b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
      for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic gray_word_t gray_max(input int width);
      return {GRAY_MAXW{1'b1}} >> (GRAY_MAXW - width);
   endfunction

endpackage

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - registered up/down Gray-code counter with load
//
// Purpose: a single binary count register with matching registered Gray and
// binary views. Both views are loaded from the same next value, so they never
// disagree and the Gray output is glitch-free (never derived from bin_out).
//
// Parameters:
//   WIDTH      counter width (2..GRAY_MAXW)
//   WRAP       1 = wrap between MAX and 0, 0 = saturate at the ends
//   RESET_VAL  binary count value applied by reset
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   en            in   count enable, one step per cycle
//   up            in   direction, 1 = increment, 0 = decrement
//   load          in   synchronous load strobe, overrides en
//   load_is_gray  in   1 = load_val is Gray-coded, 0 = binary
//   load_val      in   value to load
//   gray_out      out  registered Gray code of the count
//   bin_out       out  registered binary count
//   tc            out  combinational terminal count for the live direction
//   wrap_pulse    out  registered, one cycle high after a wrapping step
module gray_counter
   import gray_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter bit               WRAP      = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic             load_is_gray,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             tc,
   output logic             wrap_pulse
);

   localparam logic [WIDTH-1:0] MAX        = WIDTH'(gray_max(WIDTH));
   localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin2gray(GRAY_MAXW'(RESET_VAL)));

   logic [WIDTH-1:0] cnt_q,  cnt_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;
   step_e            step;

   always_comb begin
      step = STEP_HOLD;
      if (load) begin
         step = STEP_LOAD;
      end else if (en) begin
         step = up ? STEP_INC : STEP_DEC;
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      unique case (step)
         STEP_LOAD: begin
            cnt_d = load_is_gray ? WIDTH'(gray2bin(GRAY_MAXW'(load_val))) : load_val;
         end
         STEP_INC: begin
            if (cnt_q == MAX) begin
               // Saturating build leaves the count parked at MAX.
               if (WRAP) begin
                  cnt_d  = '0;
                  wrap_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STEP_DEC: begin
            if (cnt_q == '0) begin
               if (WRAP) begin
                  cnt_d  = MAX;
                  wrap_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
         end
      endcase
      // Gray view comes from the next count, not from the registered binary.
      gray_d = WIDTH'(bin2gray(GRAY_MAXW'(cnt_d)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= RESET_VAL;
         gray_q <= RESET_GRAY;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bin_out    = cnt_q;
   assign gray_out   = gray_q;
   assign wrap_pulse = wrap_q;
   assign tc         = (up && (cnt_q == MAX)) || (!up && (cnt_q == '0));

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - scoreboard bench for gray_counter
module tb_gray_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, up, load, load_is_gray;
   logic [7:0] load_val;

   logic [3:0] bin0, gray0, bin1, gray1, bin2, gray2;
   logic [7:0] bin3, gray3;
   logic       tc0, tc1, tc2, tc3, wp0, wp1, wp2, wp3;

   always #5 clk = ~clk;

   gray_counter #(.WIDTH(4), .WRAP(1'b1), .RESET_VAL(4'd0)) u_wrap4 (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
      .load_is_gray(load_is_gray), .load_val(load_val[3:0]),
      .gray_out(gray0), .bin_out(bin0), .tc(tc0), .wrap_pulse(wp0));

   gray_counter #(.WIDTH(4), .WRAP(1'b0), .RESET_VAL(4'd0)) u_sat4 (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
      .load_is_gray(load_is_gray), .load_val(load_val[3:0]),
      .gray_out(gray1), .bin_out(bin1), .tc(tc1), .wrap_pulse(wp1));

   gray_counter #(.WIDTH(4), .WRAP(1'b1), .RESET_VAL(4'd3)) u_rst3 (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
      .load_is_gray(load_is_gray), .load_val(load_val[3:0]),
      .gray_out(gray2), .bin_out(bin2), .tc(tc2), .wrap_pulse(wp2));

   gray_counter #(.WIDTH(8), .WRAP(1'b1), .RESET_VAL(8'd0)) u_wrap8 (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
      .load_is_gray(load_is_gray), .load_val(load_val),
      .gray_out(gray3), .bin_out(bin3), .tc(tc3), .wrap_pulse(wp3));

   logic [3:0][7:0] obs_bin, obs_gray;
   logic [3:0]      obs_tc, obs_wp;

   assign obs_bin[0]  = {4'h0, bin0};
   assign obs_bin[1]  = {4'h0, bin1};
   assign obs_bin[2]  = {4'h0, bin2};
   assign obs_bin[3]  = bin3;
   assign obs_gray[0] = {4'h0, gray0};
   assign obs_gray[1] = {4'h0, gray1};
   assign obs_gray[2] = {4'h0, gray2};
   assign obs_gray[3] = gray3;
   assign obs_tc      = {tc3, tc2, tc1, tc0};
   assign obs_wp      = {wp3, wp2, wp1, wp0};

   typedef struct packed {
      logic [3:0][7:0] bin;
      logic [3:0][7:0] gray;
      logic [3:0]      wp;
      logic [3:0]      chg;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   mcnt[4];

   function automatic int wid(input int i);
      return (i == 3) ? 8 : 4;
   endfunction

   function automatic int rval(input int i);
      return (i == 2) ? 3 : 0;
   endfunction

   function automatic bit wrp(input int i);
      return (i != 1);
   endfunction

   function automatic logic [7:0] g2b(input logic [7:0] g, input int w);
      logic [7:0] b;
      logic       acc;
      b   = '0;
      acc = 1'b0;
      for (int k = 7; k >= 0; k--) begin
         if (k < w) begin
            acc  = acc ^ g[k];
            b[k] = acc;
         end
      end
      return b;
   endfunction

   task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic check_reset();
      for (int i = 0; i < 4; i++) begin
         mcnt[i] = rval(i);
         chk($sformatf("rst_bin%0d", i), obs_bin[i], 8'(rval(i)));
         chk($sformatf("rst_gray%0d", i), obs_gray[i], 8'(rval(i) ^ (rval(i) >> 1)));
         chk($sformatf("rst_wp%0d", i), {7'h0, obs_wp[i]}, 8'h00);
      end
   endtask

   // Model one clock edge for every instance, queue the expectation, then
   // compare once the registered outputs have settled.
   task automatic cycle();
      exp_t            e;
      logic [3:0][7:0] pg;
      int              mx, nx;
      bit              w, tce;
      e  = '0;
      pg = obs_gray;
      for (int i = 0; i < 4; i++) begin
         mx = (1 << wid(i)) - 1;
         nx = mcnt[i];
         w  = 1'b0;
         if (load) begin
            nx = load_is_gray ? int'(g2b(load_val & 8'(mx), wid(i))) : (int'(load_val) & mx);
         end else if (en && up) begin
            if (mcnt[i] == mx) begin
               if (wrp(i)) begin nx = 0; w = 1'b1; end
            end else nx = mcnt[i] + 1;
         end else if (en) begin
            if (mcnt[i] == 0) begin
               if (wrp(i)) begin nx = mx; w = 1'b1; end
            end else nx = mcnt[i] - 1;
         end
         e.bin[i]  = 8'(nx);
         e.gray[i] = 8'(nx ^ (nx >> 1));
         e.wp[i]   = w;
         e.chg[i]  = (nx != mcnt[i]);
         mcnt[i]   = nx;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
         mx  = (1 << wid(i)) - 1;
         tce = (up && mcnt[i] == mx) || (!up && mcnt[i] == 0);
         chk($sformatf("bin%0d", i), obs_bin[i], e.bin[i]);
         chk($sformatf("gray%0d", i), obs_gray[i], e.gray[i]);
         chk($sformatf("wp%0d", i), {7'h0, obs_wp[i]}, {7'h0, e.wp[i]});
         chk($sformatf("tc%0d", i), {7'h0, obs_tc[i]}, {7'h0, tce});
         if (!load) begin
            chk($sformatf("onebit%0d", i), 8'($countones(obs_gray[i] ^ pg[i])), {7'h0, e.chg[i]});
         end
      end
      chk("g2b_consistent", g2b(obs_gray[3], 8), e.bin[3]);
   endtask

   initial begin
      rst_n        = 1'b0;
      en           = 1'b0;
      up           = 1'b0;
      load         = 1'b0;
      load_is_gray = 1'b0;
      load_val     = 8'h00;
      #12;
      check_reset();
      chk("rst_tc0", {7'h0, tc0}, 8'h01);
      chk("rst_tc2", {7'h0, tc2}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Full up sweep with wrap.
      en = 1'b1;
      up = 1'b1;
      repeat (15) cycle();
      chk("top_gray", obs_gray[0], 8'h08);
      chk("top_tc", {7'h0, tc0}, 8'h01);
      cycle();
      chk("wrap_bin", obs_bin[0], 8'h00);
      chk("wrap_pulse", {7'h0, wp0}, 8'h01);
      cycle();
      chk("wrap_pulse_drop", {7'h0, wp0}, 8'h00);

      // Gray load, then count down through zero.
      en           = 1'b0;
      load         = 1'b1;
      load_is_gray = 1'b1;
      load_val     = 8'h0D;
      cycle();
      chk("gload_bin", obs_bin[0], 8'd9);
      chk("gload_gray", obs_gray[0], 8'h0D);
      load = 1'b0;
      en   = 1'b1;
      up   = 1'b0;
      repeat (9) cycle();
      chk("down_zero", obs_bin[0], 8'd0);
      chk("down_tc", {7'h0, tc0}, 8'h01);
      cycle();
      chk("down_wrap_bin", obs_bin[0], 8'd15);
      chk("down_wrap_pulse", {7'h0, wp0}, 8'h01);

      // Saturating instance parks at MAX.
      en           = 1'b0;
      load         = 1'b1;
      load_is_gray = 1'b0;
      load_val     = 8'd14;
      cycle();
      load = 1'b0;
      en   = 1'b1;
      up   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("sat_bin", obs_bin[1], 8'd15);
         chk("sat_gray", obs_gray[1], 8'h08);
         chk("sat_tc", {7'h0, tc1}, 8'h01);
         chk("sat_wp", {7'h0, wp1}, 8'h00);
      end

      // Load beats enable.
      load     = 1'b1;
      load_val = 8'd5;
      cycle();
      chk("load_prio_bin", obs_bin[0], 8'd5);
      chk("load_prio_wp", {7'h0, wp0}, 8'h00);
      load = 1'b0;

      // Asynchronous reset mid-count.
      repeat (2) cycle();
      chk("pre_rst_bin", obs_bin[2], 8'd7);
      #2;
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      check_reset();
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      up    = 1'b1;
      cycle();
      chk("resume_bin", obs_bin[2], 8'd4);

      // Wide sweep with direction changes.
      en       = 1'b0;
      load     = 1'b1;
      load_val = 8'd0;
      cycle();
      load = 1'b0;
      en   = 1'b1;
      up   = 1'b1;
      repeat (260) cycle();
      up = 1'b0;
      repeat (260) cycle();
      repeat (200) begin
         up = 1'($urandom_range(0, 1));
         en = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
